// File: rtl/hilo_div_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_if
//   Bundles the ALU-side signals of the HI/LO register unit.
//   master : ALU / EX stage (drives writes and divide requests, reads HI/LO)
//   slave  : hilo_div_unit (owns HI/LO and the iterative divider)
//
//   HiLoEn     ALU -> unit   commit HiLoWrite into {HI,LO}
//   HiLoWrite  ALU -> unit   64-bit {HI,LO} value
//   DivStart   ALU -> unit   request a divide (honoured only when idle)
//   DivSigned  ALU -> unit   1 = DIV (two's complement), 0 = DIVU
//   A, B       ALU -> unit   dividend / divisor
//   HiLoRead   unit -> ALU   registered {HI,LO}
//   Busy       unit -> ALU   divide in progress
//   DivDone    unit -> ALU   one-cycle pulse when a divide retires
//   DivByZero  unit -> ALU   one-cycle pulse alongside DivDone when B == 0
// -----------------------------------------------------------------------------
interface hilo_div_unit_if;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        DivStart;
    logic        DivSigned;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] HiLoRead;
    logic        Busy;
    logic        DivDone;
    logic        DivByZero;

    modport master (
        output HiLoEn,
        output HiLoWrite,
        output DivStart,
        output DivSigned,
        output A,
        output B,
        input  HiLoRead,
        input  Busy,
        input  DivDone,
        input  DivByZero
    );

    modport slave (
        input  HiLoEn,
        input  HiLoWrite,
        input  DivStart,
        input  DivSigned,
        input  A,
        input  B,
        output HiLoRead,
        output Busy,
        output DivDone,
        output DivByZero
    );
endinterface

// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
//   Architectural HI/LO register pair with an optional iterative divider.
//   Single-cycle ALU writes (MULT/MULTU/MADD/MSUB/MTHI/MTLO) commit on HiLoEn and
//   are visible on HiLoRead one cycle later. With HILO_DIV_EN defined, a 32-step
//   restoring divider computes DIV/DIVU and writes HI=remainder, LO=quotient.
//
//   Configuration macro: HILO_DIV_EN
//     defined   : divider, IDLE->DIV->FIX FSM, Busy/DivDone/DivByZero active
//     undefined : plain HiLoEn-gated 64-bit register; divide inputs ignored,
//                 Busy/DivDone/DivByZero tied to 0
//
//   Ports
//     Clk    in  rising-edge clock
//     Rst_n  in  asynchronous active-low reset
//     bus    slave modport of hilo_div_unit_if (see interface header)
//
//   Parameters
//     DIV_STEPS   iterations per divide; tied to the 32-bit operand width
//     RESET_HILO  {HI,LO} value loaded on reset
// -----------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int unsigned DIV_STEPS  = 32,
    parameter logic [63:0] RESET_HILO = 64'h0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    hilo_div_unit_if.slave    bus
);

    logic [63:0] hilo_q, hilo_d;

`ifdef HILO_DIV_EN

    localparam int unsigned CntW = $clog2(DIV_STEPS);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFix
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rem_q, rem_d;     // partial remainder (always < divisor)
    logic [31:0]     quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [31:0]     dvs_q, dvs_d;     // divisor magnitude
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;              // 33-bit working remainder for the trial
    logic [33:0] diff;                 // extra bit is the borrow of the trial
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        // Magnitudes; -(32'h8000_0000) wraps to itself, which read unsigned is 2^31.
        a_mag = (bus.DivSigned && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
        b_mag = (bus.DivSigned && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};

        quo_fix = q_neg_q ? (32'd0 - quo_q) : quo_q;
        rem_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        hilo_d  = bus.HiLoEn ? bus.HiLoWrite : hilo_q;

        case (state_q)
            StIdle: begin
                if (bus.DivStart) begin
                    if (bus.B == 32'd0) begin
                        // Retire immediately; HI/LO untouched by the divide.
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        state_d = StDiv;
                        cnt_d   = '0;
                        rem_d   = 32'd0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        q_neg_d = bus.DivSigned & (bus.A[31] ^ bus.B[31]);
                        r_neg_d = bus.DivSigned & bus.A[31];
                    end
                end
            end
            StDiv: begin
                if (!diff[33]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                hilo_d  = {rem_fix, quo_fix};
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An ALU write while the divider is active aborts it and wins HI/LO.
        if (bus.HiLoEn && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hilo_d  = bus.HiLoWrite;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hilo_q  <= RESET_HILO;
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            hilo_q  <= hilo_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.HiLoRead  = hilo_q;
    assign bus.Busy      = busy_q;
    assign bus.DivDone   = done_q;
    assign bus.DivByZero = dbz_q;

`else

    logic unused_div;
    assign unused_div = ^{bus.DivStart, bus.DivSigned, bus.A, bus.B, 32'(DIV_STEPS)};

    always_comb begin
        hilo_d = bus.HiLoEn ? bus.HiLoWrite : hilo_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hilo_q <= RESET_HILO;
        end else begin
            hilo_q <= hilo_d;
        end
    end

    assign bus.HiLoRead  = hilo_q;
    assign bus.Busy      = 1'b0;
    assign bus.DivDone   = 1'b0;
    assign bus.DivByZero = 1'b0;

`endif

endmodule
